// File: rtl/ppu_vblank_nmi_gen.sv
// PPU raster position counter, PPUSTATUS flag owner and NMI source toward the CPU.
// Also serves $2002 reads with the read-clear side effects and the vblank/read race.
module ppu_vblank_nmi_gen #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_en,
    input  logic       rendering_en,
    input  logic       sprite0_hit_in,
    input  logic       spr_ovf_in,
    input  logic [2:0] reg_sel,
    input  logic       reg_rd,
    input  logic       reg_wr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic [7:0] ppu_status,
    output logic       nmi_n,
    output logic       nmi_pulse,
    output logic       w_toggle_clr,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic       frame_odd
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_SKIP  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] LINE_VBL  = 9'(VBLANK_LINE);
    localparam logic [8:0] LINE_PRE  = 9'(PRERENDER_LINE);

    // flags = {vblank, spr0_hit, spr_ovf}
    logic [2:0] flags, flags_nxt;
    logic       nmi_enable, nmi_enable_nxt;
    logic [8:0] dot_nxt, line_nxt;
    logic       odd_nxt;
    logic       land_vblank, land_pre;
    logic       rd_status, wr_ctrl;
    logic       nmi_level_nxt;

    assign ppu_status = {flags, 5'b0};
    assign rd_status  = reg_rd && (reg_sel == 3'd2);
    assign wr_ctrl    = reg_wr && (reg_sel == 3'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dot_nxt  = dot;
        line_nxt = scanline;
        odd_nxt  = frame_odd;
        if (dot_en) begin
            if (rendering_en && frame_odd && scanline == LINE_PRE && dot == DOT_SKIP) begin
                dot_nxt  = '0;
                line_nxt = '0;
                odd_nxt  = ~frame_odd;
            end else if (dot == DOT_LAST) begin
                dot_nxt = '0;
                if (scanline == LINE_LAST) begin
                    line_nxt = '0;
                    odd_nxt  = ~frame_odd;
                end else begin
                    line_nxt = scanline + 9'd1;
                end
            end else begin
                dot_nxt = dot + 9'd1;
            end
        end
    end

    assign land_vblank = dot_en && line_nxt == LINE_VBL && dot_nxt == 9'd1;
    assign land_pre    = dot_en && line_nxt == LINE_PRE && dot_nxt == 9'd1;

    // Priority is by order: a $2002 read beats the vblank set (NMI suppression),
    // and the prerender clear beats everything.
    always_comb begin
        flags_nxt = flags;
        if (sprite0_hit_in) flags_nxt[1] = 1'b1;
        if (spr_ovf_in)     flags_nxt[0] = 1'b1;
        if (land_vblank)    flags_nxt[2] = 1'b1;
        if (rd_status)      flags_nxt[2] = 1'b0;
        if (land_pre)       flags_nxt    = 3'b000;
        nmi_enable_nxt = wr_ctrl ? reg_wdata[7] : nmi_enable;
        nmi_level_nxt  = flags_nxt[2] & nmi_enable_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dot          <= '0;
            scanline     <= '0;
            frame_odd    <= 1'b0;
            flags        <= 3'b000;
            nmi_enable   <= 1'b0;
            reg_rdata    <= 8'h00;
            nmi_n        <= 1'b1;
            nmi_pulse    <= 1'b0;
            w_toggle_clr <= 1'b0;
        end else begin
            dot          <= dot_nxt;
            scanline     <= line_nxt;
            frame_odd    <= odd_nxt;
            flags        <= flags_nxt;
            nmi_enable   <= nmi_enable_nxt;
            // nmi_n is low exactly while the level is high, so it doubles as the previous level.
            nmi_n        <= ~nmi_level_nxt;
            nmi_pulse    <= nmi_level_nxt & nmi_n;
            w_toggle_clr <= rd_status;
            if (rd_status) reg_rdata <= ppu_status;
        end
    end

endmodule

// File: tb/tb_ppu_vblank_nmi_gen.sv
// Self-checking bench for ppu_vblank_nmi_gen using a scaled-down raster so whole
// frames fit in a short run; read data is checked through an expected-value queue.
module tb_ppu_vblank_nmi_gen;

    localparam int D   = 24;
    localparam int L   = 16;
    localparam int VB  = 11;
    localparam int PRE = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dot_en = 1'b0;
    logic       rendering_en = 1'b0;
    logic       sprite0_hit_in = 1'b0;
    logic       spr_ovf_in = 1'b0;
    logic [2:0] reg_sel = 3'd0;
    logic       reg_rd = 1'b0;
    logic       reg_wr = 1'b0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata;
    logic [7:0] ppu_status;
    logic       nmi_n;
    logic       nmi_pulse;
    logic       w_toggle_clr;
    logic [8:0] dot;
    logic [8:0] scanline;
    logic       frame_odd;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int idx = 0;
    bit m_odd = 1'b0;
    logic [7:0] rd_q[$];

    ppu_vblank_nmi_gen #(
        .DOTS_PER_LINE(D), .LINES_PER_FRAME(L), .VBLANK_LINE(VB), .PRERENDER_LINE(PRE)
    ) dut (
        .clk(clk), .rst(rst), .dot_en(dot_en), .rendering_en(rendering_en),
        .sprite0_hit_in(sprite0_hit_in), .spr_ovf_in(spr_ovf_in),
        .reg_sel(reg_sel), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .ppu_status(ppu_status), .nmi_n(nmi_n),
        .nmi_pulse(nmi_pulse), .w_toggle_clr(w_toggle_clr), .dot(dot),
        .scanline(scanline), .frame_odd(frame_odd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (nmi_pulse === 1'b1) pulse_cnt++;

    // Linear-index raster model: the frame's last index shrinks by one on skipping frames.
    task automatic tick();
        int last;
        if (rst && dot_en) begin
            last = (rendering_en && m_odd) ? D * L - 2 : D * L - 1;
            if (idx == last) begin
                idx   = 0;
                m_odd = ~m_odd;
            end else begin
                idx++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int line, input int d);
        int n = 0;
        do begin
            tick();
            n++;
        end while (idx != line * D + d && n < 2 * D * L);
        checks++;
        if (n >= 2 * D * L || {scanline, dot} !== {9'(line), 9'(d)}) begin
            errors++;
            $display("FAIL run_to: pos=(%0d,%0d) expected (%0d,%0d) steps=%0d",
                     scanline, dot, line, d, n);
        end
    endtask

    task automatic cpu_read(input logic [2:0] sel, input logic [7:0] exp);
        logic [7:0] want;
        rd_q.push_back(exp);
        reg_sel = sel;
        reg_rd  = 1'b1;
        tick();
        reg_rd = 1'b0;
        want = rd_q.pop_front();
        checks++;
        if (reg_rdata !== want) begin
            errors++;
            $display("FAIL read_data sel=%0d: got %h expected %h", sel, reg_rdata, want);
        end
        checks++;
        if (w_toggle_clr !== (sel == 3'd2)) begin
            errors++;
            $display("FAIL w_toggle_clr sel=%0d: got %b expected %b", sel, w_toggle_clr, sel == 3'd2);
        end
    endtask

    task automatic cpu_write(input logic [2:0] sel, input logic [7:0] data);
        reg_sel   = sel;
        reg_wdata = data;
        reg_wr    = 1'b1;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        dot_en = 1'b1;
        #2;
        run(3);
        checks++;
        if ({reg_rdata, ppu_status, nmi_n, nmi_pulse, w_toggle_clr, dot, scanline, frame_odd}
            !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: rdata=%h status=%h nmi_n=%b pulse=%b wclr=%b pos=(%0d,%0d) odd=%b",
                     reg_rdata, ppu_status, nmi_n, nmi_pulse, w_toggle_clr, scanline, dot, frame_odd);
        end
        rst = 1'b1;
        idx = 0;
        m_odd = 1'b0;
    endtask

    task automatic test_vblank_flag();
        run(VB * D + 1);
        checks++;
        if ({scanline, dot, ppu_status, nmi_n} !== {9'(VB), 9'd1, 8'h80, 1'b1} || pulse_cnt != 0) begin
            errors++;
            $display("FAIL vblank_set: pos=(%0d,%0d) status=%h nmi_n=%b pulses=%0d expected (%0d,1) 80 1 0",
                     scanline, dot, ppu_status, nmi_n, pulse_cnt, VB);
        end
        run_to(PRE, 1);
        checks++;
        if (ppu_status !== 8'h00) begin
            errors++;
            $display("FAIL prerender_clear: status=%h expected 00", ppu_status);
        end
        run_to(0, 0);
        checks++;
        if (frame_odd !== 1'b1) begin
            errors++;
            $display("FAIL frame_toggle: frame_odd=%b expected 1", frame_odd);
        end
    endtask

    task automatic test_nmi_enable();
        int p0;
        cpu_write(3'd0, 8'h80);
        run_to(VB, 0);
        p0 = pulse_cnt;
        checks++;
        if (nmi_n !== 1'b1) begin
            errors++;
            $display("FAIL nmi_before_vblank: nmi_n=%b expected 1", nmi_n);
        end
        run_to(VB, 1);
        checks++;
        if ({nmi_pulse, nmi_n, ppu_status} !== {1'b1, 1'b0, 8'h80}) begin
            errors++;
            $display("FAIL nmi_assert: pulse=%b nmi_n=%b status=%h expected 1 0 80", nmi_pulse, nmi_n, ppu_status);
        end
        tick();
        checks++;
        if ({nmi_pulse, nmi_n} !== 2'b00) begin
            errors++;
            $display("FAIL nmi_pulse_width: pulse=%b nmi_n=%b expected 0 0", nmi_pulse, nmi_n);
        end
        run_to(PRE, 0);
        checks++;
        if (nmi_n !== 1'b0 || pulse_cnt != p0 + 1) begin
            errors++;
            $display("FAIL nmi_hold: nmi_n=%b pulses=%0d expected 0 and %0d", nmi_n, pulse_cnt, p0 + 1);
        end
        run_to(PRE, 1);
        checks++;
        if ({ppu_status, nmi_n} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL nmi_release: status=%h nmi_n=%b expected 00 1", ppu_status, nmi_n);
        end
        run_to(0, 0);
    endtask

    task automatic test_status_read();
        run_to(VB, 5);
        checks++;
        if (nmi_n !== 1'b0) begin
            errors++;
            $display("FAIL read_setup: nmi_n=%b expected 0", nmi_n);
        end
        cpu_read(3'd2, 8'h80);
        checks++;
        if ({ppu_status, nmi_n} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL read_clear: status=%h nmi_n=%b expected 00 1", ppu_status, nmi_n);
        end
        cpu_read(3'd1, 8'h80);
        cpu_read(3'd2, 8'h00);
        run_to(0, 0);
    endtask

    task automatic test_read_race();
        int p0;
        run_to(VB, 0);
        p0 = pulse_cnt;
        cpu_read(3'd2, 8'h00);
        checks++;
        if ({scanline, dot, ppu_status, nmi_n} !== {9'(VB), 9'd1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL race_suppress: pos=(%0d,%0d) status=%h nmi_n=%b expected (%0d,1) 00 1",
                     scanline, dot, ppu_status, nmi_n, VB);
        end
        run_to(PRE, 0);
        checks++;
        if (ppu_status !== 8'h00 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL race_frame: status=%h pulses=%0d expected 00 and %0d", ppu_status, pulse_cnt, p0);
        end
        run_to(0, 0);
    endtask

    task automatic test_sprite_flags_and_retrigger();
        int p0;
        cpu_write(3'd0, 8'h00);
        run_to(3, 0);
        sprite0_hit_in = 1'b1;
        tick();
        sprite0_hit_in = 1'b0;
        run_to(5, 0);
        spr_ovf_in = 1'b1;
        tick();
        spr_ovf_in = 1'b0;
        checks++;
        if (ppu_status !== 8'h60) begin
            errors++;
            $display("FAIL sprite_flags: status=%h expected 60", ppu_status);
        end
        run_to(VB, 2);
        p0 = pulse_cnt;
        checks++;
        if ({ppu_status, nmi_n} !== {8'hE0, 1'b1}) begin
            errors++;
            $display("FAIL vblank_no_enable: status=%h nmi_n=%b expected e0 1", ppu_status, nmi_n);
        end
        cpu_write(3'd0, 8'h80);
        checks++;
        if ({nmi_pulse, nmi_n} !== 2'b10 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL nmi_retrigger: pulse=%b nmi_n=%b expected 1 0", nmi_pulse, nmi_n);
        end
        run_to(PRE, 0);
        sprite0_hit_in = 1'b1;
        cpu_read(3'd2, 8'hE0);
        sprite0_hit_in = 1'b0;
        checks++;
        if ({ppu_status, nmi_n} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL prerender_wins: status=%h nmi_n=%b expected 00 1", ppu_status, nmi_n);
        end
        run_to(0, 0);
    endtask

    task automatic test_dot_en_hold();
        run_to(VB, 0);
        dot_en = 1'b0;
        run(5);
        cpu_read(3'd2, 8'h00);
        checks++;
        if ({scanline, dot, ppu_status} !== {9'(VB), 9'd0, 8'h00}) begin
            errors++;
            $display("FAIL dot_en_hold: pos=(%0d,%0d) status=%h expected (%0d,0) 00", scanline, dot, ppu_status, VB);
        end
        dot_en = 1'b1;
        tick();
        checks++;
        if ({scanline, dot, ppu_status, nmi_pulse} !== {9'(VB), 9'd1, 8'h80, 1'b1}) begin
            errors++;
            $display("FAIL dot_en_resume: pos=(%0d,%0d) status=%h pulse=%b expected (%0d,1) 80 1",
                     scanline, dot, ppu_status, nmi_pulse, VB);
        end
        run_to(0, 0);
    endtask

    task automatic test_frame_lengths();
        logic [18:0] want [6];
        logic [18:0] got;
        checks++;
        if (frame_odd !== 1'b0) begin
            errors++;
            $display("FAIL frame_parity: frame_odd=%b expected 0", frame_odd);
        end
        want[0] = {9'd0, 9'd0, 1'b1};
        want[1] = {9'(PRE), 9'(D - 2), 1'b1};
        want[2] = {9'd0, 9'd0, 1'b0};
        want[3] = {9'd0, 9'd0, 1'b1};
        want[4] = {9'(PRE), 9'(D - 1), 1'b1};
        want[5] = {9'd0, 9'd0, 1'b0};
        rendering_en = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s == 3) rendering_en = 1'b0;
            case (s)
                0, 3:    run(D * L);
                1:       run(D * L - 2);
                4:       run(D * L - 1);
                default: run(1);
            endcase
            got = {scanline, dot, frame_odd};
            checks++;
            if (got !== want[s]) begin
                errors++;
                $display("FAIL frame_len step %0d: pos=(%0d,%0d) odd=%b expected (%0d,%0d) odd=%b",
                         s, got[18:10], got[9:1], got[0], want[s][18:10], want[s][9:1], want[s][0]);
            end
        end
    endtask

    task automatic test_reset_mid_vblank();
        run_to(VB, 3);
        checks++;
        if (nmi_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_setup: nmi_n=%b expected 0", nmi_n);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({reg_rdata, ppu_status, nmi_n, nmi_pulse, w_toggle_clr, dot, scanline, frame_odd}
            !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: status=%h nmi_n=%b pos=(%0d,%0d) odd=%b",
                     ppu_status, nmi_n, scanline, dot, frame_odd);
        end
        tick();
        rst = 1'b1;
        idx = 0;
        m_odd = 1'b0;
        tick();
        checks++;
        if ({scanline, dot, frame_odd} !== {9'd0, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL restart: pos=(%0d,%0d) odd=%b expected (0,1) 0", scanline, dot, frame_odd);
        end
        run_to(VB, 1);
        checks++;
        if ({ppu_status, nmi_n} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL enable_reset: status=%h nmi_n=%b expected 80 1", ppu_status, nmi_n);
        end
    endtask

    initial begin
        test_reset();
        test_vblank_flag();
        test_nmi_enable();
        test_status_read();
        test_read_race();
        test_sprite_flags_and_retrigger();
        test_dot_en_hold();
        test_frame_lengths();
        test_reset_mid_vblank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
